// File: rtl/regfile_scoreboard_pkg.sv
// Shared definitions for the register file / load scoreboard slice.
//   DEF_DATA_W   : default register width in bits
//   DEF_NREGS    : default number of architectural registers
//   DEF_LINK_REG : default register written by call (link) writebacks
//   wsrc_e       : per-register write source selection
//   addr_width() : ceil(log2(n)) used to size register indices
package regfile_scoreboard_pkg;

  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_NREGS    = 16;
  localparam int unsigned DEF_LINK_REG = 15;

  typedef enum logic [1:0] {
    WSRC_NONE   = 2'd0,
    WSRC_PORT_A = 2'd1,
    WSRC_PORT_B = 2'd2
  } wsrc_e;

  function automatic int unsigned addr_width(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/regfile_bypass_mux.sv
// One forwarded read port of the register file.
//   rd_addr_i  : read address
//   stored_i   : stored register value at rd_addr_i
//   fwd_en_i   : forwarding permitted (deasserted while in reset)
//   wa_*_i     : ALU writeback (effective address already resolved)
//   wb_*_i     : load-return writeback
//   rd_data_o  : read data; index 0 always reads zero
module regfile_bypass_mux
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned AW     = 4,
  parameter int unsigned BYPASS = 1
) (
  input  logic [AW-1:0]     rd_addr_i,
  input  logic [DATA_W-1:0] stored_i,
  input  logic              fwd_en_i,
  input  logic              wa_en_i,
  input  logic [AW-1:0]     wa_addr_i,
  input  logic [DATA_W-1:0] wa_data_i,
  input  logic              wb_en_i,
  input  logic [AW-1:0]     wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic [DATA_W-1:0] rd_data_o
);

  always_comb begin
    rd_data_o = stored_i;
    if (rd_addr_i == '0) begin
      rd_data_o = '0;
    end else if ((BYPASS != 0) && fwd_en_i) begin
      // Port A has priority, matching the write-port resolution.
      if (wa_en_i && (wa_addr_i == rd_addr_i)) begin
        rd_data_o = wa_data_i;
      end else if (wb_en_i && (wb_addr_i == rd_addr_i)) begin
        rd_data_o = wb_data_i;
      end
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Two-write / two-read register file with a pending-load scoreboard.
//   clk, reset          : clock, asynchronous active-high reset
//   rs_addr/rt_addr     : read addresses; rs_data/rt_data forwarded read data
//   wa_en/addr/data/link: ALU writeback; wa_link redirects to LINK_REG
//   wb_en/addr/data     : load-return writeback; clears the busy bit
//   iss_*               : issue request; iss_ready when no source/dest is busy
//   busy                : per-register pending-load bits
//   dbg_addr/dbg_data   : unforwarded debug read
//   wr_err              : sticky write-conflict flag
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NREGS    = DEF_NREGS,
  parameter int unsigned LINK_REG = DEF_LINK_REG,
  parameter int unsigned BYPASS   = 1,
  localparam int unsigned AW      = addr_width(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     rs_addr,
  input  logic [AW-1:0]     rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wa_en,
  input  logic [AW-1:0]     wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  input  logic              wa_link,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rs,
  input  logic [AW-1:0]     iss_rt,
  input  logic [AW-1:0]     iss_rd,
  input  logic              iss_load,
  output logic              iss_ready,
  output logic [NREGS-1:0]  busy,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              wr_err
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  wsrc_e             wsrc   [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d, busy_eff, wb_clr, iss_set;
  logic              wr_err_q, wr_err_d;

  logic [AW-1:0]     wa_addr_eff;
  logic              wa_hit_nz, wb_hit_nz;
  logic              dual_conflict, busy_conflict;

  assign wa_addr_eff = wa_link ? AW'(LINK_REG) : wa_addr;
  assign wa_hit_nz   = wa_en && (wa_addr_eff != '0);
  assign wb_hit_nz   = wb_en && (wb_addr != '0);

  // Write-port resolution: port A wins over port B; r0 is never written.
  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) begin
      wsrc[i]   = WSRC_NONE;
      regs_d[i] = regs_q[i];
      if (i != 0) begin
        if (wa_en && (wa_addr_eff == AW'(i))) begin
          wsrc[i] = WSRC_PORT_A;
        end else if (wb_en && (wb_addr == AW'(i))) begin
          wsrc[i] = WSRC_PORT_B;
        end
      end
      case (wsrc[i])
        WSRC_PORT_A: regs_d[i] = wa_data;
        WSRC_PORT_B: regs_d[i] = wb_data;
        default:     regs_d[i] = regs_q[i];
      endcase
    end
  end

  // Scoreboard: a same-cycle load return frees its register for issue;
  // bit 0 is masked so index 0 never blocks. Set-after-clear gives set priority.
  always_comb begin
    wb_clr    = wb_hit_nz ? (NREGS'(1) << wb_addr) : '0;
    busy_eff  = busy_q & ~wb_clr & ~NREGS'(1);
    iss_ready = iss_valid && !busy_eff[iss_rs] && !busy_eff[iss_rt]
                          && !busy_eff[iss_rd];
    iss_set   = (iss_ready && iss_load && (iss_rd != '0))
                ? (NREGS'(1) << iss_rd) : '0;
    busy_d    = busy_eff | iss_set;
  end

  always_comb begin
    dual_conflict = wa_hit_nz && wb_en && (wb_addr == wa_addr_eff);
    busy_conflict = wa_hit_nz && busy_q[wa_addr_eff];
    wr_err_d      = wr_err_q || dual_conflict || busy_conflict;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
      busy_q   <= '0;
      wr_err_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
      busy_q   <= busy_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign busy     = busy_q;
  assign wr_err   = wr_err_q;
  assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

  // Forwarding is suppressed during reset so reads see the cleared file.
  regfile_bypass_mux #(
    .DATA_W (DATA_W),
    .AW     (AW),
    .BYPASS (BYPASS)
  ) u_rs_mux (
    .rd_addr_i (rs_addr),
    .stored_i  (regs_q[rs_addr]),
    .fwd_en_i  (!reset),
    .wa_en_i   (wa_en),
    .wa_addr_i (wa_addr_eff),
    .wa_data_i (wa_data),
    .wb_en_i   (wb_en),
    .wb_addr_i (wb_addr),
    .wb_data_i (wb_data),
    .rd_data_o (rs_data)
  );

  regfile_bypass_mux #(
    .DATA_W (DATA_W),
    .AW     (AW),
    .BYPASS (BYPASS)
  ) u_rt_mux (
    .rd_addr_i (rt_addr),
    .stored_i  (regs_q[rt_addr]),
    .fwd_en_i  (!reset),
    .wa_en_i   (wa_en),
    .wa_addr_i (wa_addr_eff),
    .wa_data_i (wa_data),
    .wb_en_i   (wb_en),
    .wb_addr_i (wb_addr),
    .wb_data_i (wb_data),
    .rd_data_o (rt_data)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a BYPASS=1 and a BYPASS=0 instance
// share all inputs; a vector table covers forwarding, link writes, r0,
// scoreboard and conflicts, followed by hand sequences for reset behaviour.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rs_addr, rt_addr, wa_addr, wb_addr, iss_rs, iss_rt, iss_rd, dbg_addr;
  logic [31:0] wa_data, wb_data;
  logic        wa_en, wa_link, wb_en, iss_valid, iss_load;
  logic [31:0] rs_data, rt_data, dbg_data, rs_data_nb, rt_data_nb, dbg_data_nb;
  logic        iss_ready, wr_err, iss_ready_nb, wr_err_nb;
  logic [15:0] busy, busy_nb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.DATA_W(32), .NREGS(16), .LINK_REG(15), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .wa_en(wa_en), .wa_addr(wa_addr),
    .wa_data(wa_data), .wa_link(wa_link), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .iss_valid(iss_valid), .iss_rs(iss_rs), .iss_rt(iss_rt),
    .iss_rd(iss_rd), .iss_load(iss_load), .iss_ready(iss_ready), .busy(busy),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wr_err(wr_err)
  );

  regfile_scoreboard #(.DATA_W(32), .NREGS(16), .LINK_REG(15), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data_nb), .rt_data(rt_data_nb), .wa_en(wa_en), .wa_addr(wa_addr),
    .wa_data(wa_data), .wa_link(wa_link), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .iss_valid(iss_valid), .iss_rs(iss_rs), .iss_rt(iss_rt),
    .iss_rd(iss_rd), .iss_load(iss_load), .iss_ready(iss_ready_nb), .busy(busy_nb),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data_nb), .wr_err(wr_err_nb)
  );

  typedef struct {
    logic        wa_en;   logic [3:0] wa_addr; logic [31:0] wa_data; logic wa_link;
    logic        wb_en;   logic [3:0] wb_addr; logic [31:0] wb_data;
    logic        iss_valid; logic [3:0] iss_rs; logic [3:0] iss_rt; logic [3:0] iss_rd;
    logic        iss_load;
    logic [3:0]  rs_addr; logic [3:0] rt_addr; logic [3:0] dbg_addr;
    logic [31:0] exp_rs;  logic [31:0] exp_rt; logic [31:0] exp_rs_nb; logic [31:0] exp_dbg;
    logic        exp_ready; logic [15:0] exp_busy; logic exp_err;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wa_en = 0; wa_addr = 0; wa_data = 0; wa_link = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0;
    iss_valid = 0; iss_rs = 0; iss_rt = 0; iss_rd = 0; iss_load = 0;
    rs_addr = 0; rt_addr = 0; dbg_addr = 0;
  endtask

  task automatic apply(input vec_t v);
    wa_en = v.wa_en; wa_addr = v.wa_addr; wa_data = v.wa_data; wa_link = v.wa_link;
    wb_en = v.wb_en; wb_addr = v.wb_addr; wb_data = v.wb_data;
    iss_valid = v.iss_valid; iss_rs = v.iss_rs; iss_rt = v.iss_rt;
    iss_rd = v.iss_rd; iss_load = v.iss_load;
    rs_addr = v.rs_addr; rt_addr = v.rt_addr; dbg_addr = v.dbg_addr;
  endtask

  initial begin
    // Row expectations are the outputs seen before the rising edge of that row.
    vecs[0]  = '{default:0};
    vecs[1]  = '{wa_en:1, wa_addr:3, wa_data:32'hDEADBEEF, rs_addr:3, rt_addr:3, dbg_addr:3,
                 exp_rs:32'hDEADBEEF, exp_rt:32'hDEADBEEF, default:0};
    vecs[2]  = '{rs_addr:3, dbg_addr:3, exp_rs:32'hDEADBEEF, exp_rs_nb:32'hDEADBEEF,
                 exp_dbg:32'hDEADBEEF, default:0};
    vecs[3]  = '{wa_en:1, wa_link:1, wa_addr:5, wa_data:32'h100, rs_addr:15, rt_addr:5,
                 dbg_addr:15, exp_rs:32'h100, default:0};
    vecs[4]  = '{wa_en:1, wa_addr:0, wa_data:32'h55, rs_addr:0, rt_addr:15, dbg_addr:5,
                 exp_rt:32'h100, default:0};
    vecs[5]  = '{rt_addr:5, default:0};
    vecs[6]  = '{iss_valid:1, iss_rs:1, iss_rt:2, iss_rd:7, iss_load:1, rs_addr:3, dbg_addr:15,
                 exp_rs:32'hDEADBEEF, exp_rs_nb:32'hDEADBEEF, exp_dbg:32'h100,
                 exp_ready:1, default:0};
    vecs[7]  = '{iss_valid:1, iss_rs:7, iss_rd:1, rs_addr:7, exp_busy:16'h0080, default:0};
    vecs[8]  = '{wb_en:1, wb_addr:7, wb_data:32'h42, iss_valid:1, iss_rs:7, iss_rd:2,
                 rs_addr:7, dbg_addr:7, exp_rs:32'h42, exp_ready:1, exp_busy:16'h0080,
                 default:0};
    vecs[9]  = '{rs_addr:7, dbg_addr:7, exp_rs:32'h42, exp_rs_nb:32'h42, exp_dbg:32'h42,
                 default:0};
    vecs[10] = '{iss_valid:1, iss_rd:4, iss_load:1, exp_ready:1, default:0};
    vecs[11] = '{wb_en:1, wb_addr:4, wb_data:32'h44, iss_valid:1, iss_rd:4, iss_load:1,
                 rs_addr:4, exp_rs:32'h44, exp_ready:1, exp_busy:16'h0010, default:0};
    vecs[12] = '{iss_valid:1, iss_rd:4, rs_addr:4, dbg_addr:4, exp_rs:32'h44,
                 exp_rs_nb:32'h44, exp_dbg:32'h44, exp_busy:16'h0010, default:0};
    vecs[13] = '{wa_en:1, wa_addr:9, wa_data:32'h1, wb_en:1, wb_addr:9, wb_data:32'h2,
                 rs_addr:9, rt_addr:9, exp_rs:32'h1, exp_rt:32'h1, exp_busy:16'h0010,
                 default:0};
    vecs[14] = '{rs_addr:9, dbg_addr:9, exp_rs:32'h1, exp_rs_nb:32'h1, exp_dbg:32'h1,
                 exp_busy:16'h0010, exp_err:1, default:0};
    vecs[15] = '{exp_busy:16'h0010, exp_err:1, default:0};

    // Power-on reset
    reset = 1'b1;
    idle_inputs();
    @(negedge clk); @(negedge clk);
    #2;
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset wr_err", 32'(wr_err), 32'h0);
    chk("reset rs_data", rs_data, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i]);
      #2;
      chk($sformatf("v%0d rs_data", i), rs_data, vecs[i].exp_rs);
      chk($sformatf("v%0d rt_data", i), rt_data, vecs[i].exp_rt);
      chk($sformatf("v%0d rs_data nobypass", i), rs_data_nb, vecs[i].exp_rs_nb);
      chk($sformatf("v%0d dbg_data", i), dbg_data, vecs[i].exp_dbg);
      chk($sformatf("v%0d iss_ready", i), 32'(iss_ready), 32'(vecs[i].exp_ready));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      chk($sformatf("v%0d wr_err", i), 32'(wr_err), 32'(vecs[i].exp_err));
      @(negedge clk);
    end

    // Build up busy = 0x00F0 (r4 still pending from the table)
    for (int r = 5; r <= 7; r++) begin
      idle_inputs();
      iss_valid = 1; iss_load = 1; iss_rd = 4'(r);
      #2;
      chk($sformatf("load issue r%0d ready", r), 32'(iss_ready), 32'h1);
      @(negedge clk);
    end
    idle_inputs();
    #2;
    chk("pre-reset busy", 32'(busy), 32'h00F0);
    chk("pre-reset wr_err", 32'(wr_err), 32'h1);

    // Mid-cycle asynchronous reset with live write and issue inputs
    #1;
    reset = 1'b1;
    wa_en = 1; wa_addr = 3; wa_data = 32'h77;
    rs_addr = 3; rt_addr = 4; dbg_addr = 3;
    iss_valid = 1; iss_rs = 6; iss_rt = 7; iss_rd = 5;
    #1;
    chk("async reset busy", 32'(busy), 32'h0);
    chk("async reset wr_err", 32'(wr_err), 32'h0);
    chk("async reset rs_data", rs_data, 32'h0);
    chk("async reset rt_data", rt_data, 32'h0);
    chk("async reset dbg_data", dbg_data, 32'h0);
    chk("async reset iss_ready", 32'(iss_ready), 32'h1);
    @(negedge clk);

    // Traffic presented in the deassert cycle takes effect at the next edge
    reset = 1'b0;
    idle_inputs();
    wa_en = 1; wa_addr = 6; wa_data = 32'h66;
    iss_valid = 1; iss_rd = 8; iss_load = 1;
    #2;
    chk("post-reset iss_ready", 32'(iss_ready), 32'h1);
    @(negedge clk);
    idle_inputs();
    rs_addr = 3; dbg_addr = 6;
    #2;
    chk("post-reset r6", dbg_data, 32'h66);
    chk("post-reset r3 cleared", rs_data, 32'h0);
    chk("post-reset busy", 32'(busy), 32'h0100);
    chk("post-reset wr_err", 32'(wr_err), 32'h0);

    // Port A write to a busy register: data lands, flag sets, busy kept
    wa_en = 1; wa_addr = 8; wa_data = 32'h88; rs_addr = 8;
    #1;
    chk("busy write bypass", rs_data, 32'h88);
    @(negedge clk);
    idle_inputs();
    dbg_addr = 8;
    #2;
    chk("busy write data", dbg_data, 32'h88);
    chk("busy write wr_err", 32'(wr_err), 32'h1);
    chk("busy write busy kept", 32'(busy), 32'h0100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
